// File: rtl/regfile_access_ctrl_if.sv
// Signal bundle between the register-file access controller and its neighbours:
// instruction request, ALU operand hand-off, result writeback and register-file ports.
interface regfile_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs;
  logic [ADDR_W-1:0] req_rt;
  logic [ADDR_W-1:0] req_rd;
  logic              req_wb;

  logic              ops_valid;
  logic              ops_ready;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;

  logic [ADDR_W-1:0] rf_raddr0;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [DATA_W-1:0] rf_rdata0;
  logic [DATA_W-1:0] rf_rdata1;
  logic [ADDR_W-1:0] rf_waddr;
  logic              rf_wen;
  logic [DATA_W-1:0] rf_wdata;

  logic              busy;

  modport master (
    input  req_valid, req_rs, req_rt, req_rd, req_wb,
    output req_ready,
    output ops_valid, operand_a, operand_b,
    input  ops_ready,
    input  wb_valid, wb_data,
    output wb_ready,
    output rf_raddr0, rf_raddr1, rf_waddr, rf_wen, rf_wdata,
    input  rf_rdata0, rf_rdata1,
    output busy
  );

  modport slave (
    output req_valid, req_rs, req_rt, req_rd, req_wb,
    input  req_ready,
    input  ops_valid, operand_a, operand_b,
    output ops_ready,
    output wb_valid, wb_data,
    input  wb_ready,
    input  rf_raddr0, rf_raddr1, rf_waddr, rf_wen, rf_wdata,
    output rf_rdata0, rf_rdata1,
    input  busy
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer: fetches two operands, hands them to the ALU,
// then optionally writes the returned result back in a single-cycle pulse.
module regfile_access_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_PROT = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  regfile_access_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    HOLD    = 3'd2,
    WAIT_WB = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] rs_p0, rt_p0, rd_p0;
  logic              wb_p0;
  logic [DATA_W-1:0] operand_a_p1, operand_b_p1;
  logic              vld_p1;
  logic [ADDR_W-1:0] waddr_p2;
  logic [DATA_W-1:0] wdata_p2;
  logic              req_fire, wb_fire;

  function automatic logic write_allowed(input logic [ADDR_W-1:0] addr);
    return !(ZERO_PROT && (addr == '0));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_fire  = 1'b0;
    wb_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          req_fire  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = HOLD;
      HOLD: begin
        if (bus.ops_ready) state_nxt = wb_p0 ? WAIT_WB : IDLE;
      end
      WAIT_WB: begin
        if (bus.wb_valid) begin
          wb_fire   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: instruction fields captured on request accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_p0 <= '0;
      rt_p0 <= '0;
      rd_p0 <= '0;
      wb_p0 <= 1'b0;
    end else if (req_fire) begin
      rs_p0 <= bus.req_rs;
      rt_p0 <= bus.req_rt;
      rd_p0 <= bus.req_rd;
      wb_p0 <= bus.req_wb;
    end
  end

  // p1: operands sampled from the combinational read ports at the end of FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand_a_p1 <= '0;
      operand_b_p1 <= '0;
    end else if (state == FETCH) begin
      operand_a_p1 <= bus.rf_rdata0;
      operand_b_p1 <= bus.rf_rdata1;
    end
  end

  assign vld_p1 = (state == HOLD);

  // p2: result and destination held steady through the WRITE cycle and beyond
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr_p2 <= '0;
      wdata_p2 <= '0;
    end else if (wb_fire) begin
      waddr_p2 <= rd_p0;
      wdata_p2 <= bus.wb_data;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.ops_valid = vld_p1;
  assign bus.operand_a = operand_a_p1;
  assign bus.operand_b = operand_b_p1;
  assign bus.wb_ready  = (state == WAIT_WB);
  assign bus.busy      = (state != IDLE);

  // Read port 0 shows the destination during WRITE so a bypass/debug reader can observe it.
  assign bus.rf_raddr0 = (state == WRITE) ? rd_p0 : rs_p0;
  assign bus.rf_raddr1 = rt_p0;
  assign bus.rf_waddr  = waddr_p2;
  assign bus.rf_wdata  = wdata_p2;
  assign bus.rf_wen    = (state == WRITE) && write_allowed(waddr_p2);

endmodule
